mem_access_stage: RTL and testbench

- MEM-stage data-memory access controller between the EX/MEM pipeline register and the MEM/WB register.
- Turns a load or store from EX/MEM into a req/ack transaction on the data-memory bus.
- Stalls the upstream pipeline while the access is outstanding.
- Presents aligned, extended ReadData_MEM and a gated RegWrite to MEM/WB.
- Handles sub-word access, misalignment and bus timeout.

---
 rtl/mem_access_stage.sv | 192 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access controller: converts EX/MEM loads/stores into a
// req/ack bus transaction, stalls the pipeline while outstanding, and returns extended load data.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TCNT_W         = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  input  logic [1:0]  MemSize_MEM,
  input  logic        LoadUnsigned_MEM,
  input  logic [31:0] ALUOut_MEM,
  input  logic [31:0] WriteData_MEM,
  input  logic        RegWrite_MEM,
  output logic        RegWrite_out,
  output logic [31:0] ReadData_MEM,
  output logic        Stall_MEM,
  output logic        MemFault,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               fault_q, fault_d;
  logic [1:0]         off_q, off_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;

  logic        access;
  logic        sz_byte, sz_half;
  logic        misaligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;

  assign access  = MemRead_MEM | MemWrite_MEM;
  assign sz_byte = (MemSize_MEM == 2'b00);
  assign sz_half = (MemSize_MEM == 2'b01);
  // Size 2'b11 falls through to the word case everywhere.
  assign misaligned = (sz_half & ALUOut_MEM[0]) |
                      (!sz_byte && !sz_half && (ALUOut_MEM[1:0] != 2'b00));

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = WriteData_MEM;
    if (sz_byte) begin
      be_calc    = 4'b0001 << ALUOut_MEM[1:0];
      wdata_calc = {4{WriteData_MEM[7:0]}};
    end else if (sz_half) begin
      be_calc    = ALUOut_MEM[1] ? 4'b1100 : 4'b0011;
      wdata_calc = {2{WriteData_MEM[15:0]}};
    end
  end

  function automatic logic [31:0] load_lane(input logic [31:0] d, input logic [1:0] off,
                                            input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    case (sz)
      2'b00:   r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = d;
    endcase
    return r;
  endfunction

  // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (misaligned) begin
            fault_d = 1'b1;
            rdata_d = '0;
            state_d = S_DONE;
          end else begin
            req_d   = 1'b1;
            we_d    = MemWrite_MEM;
            addr_d  = {ALUOut_MEM[31:2], 2'b00};
            be_d    = be_calc;
            wdata_d = wdata_calc;
            off_d   = ALUOut_MEM[1:0];
            size_d  = MemSize_MEM;
            uns_d   = LoadUnsigned_MEM;
            tcnt_d  = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        tcnt_d = tcnt_q + TCNT_W'(1);
        // Ack is tested first so it wins over a coincident timeout.
        if (dmem_ack) begin
          req_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : load_lane(dmem_rdata, off_q, size_q, uns_q);
          state_d = S_DONE;
        end else if (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
          req_d   = 1'b0;
          fault_d = 1'b1;
          rdata_d = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        fault_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
    end
  end

  // Reset gates the combinational outputs so the pipeline is released while reset is held.
  assign Stall_MEM    = reset & access & (state_q != S_DONE);
  assign RegWrite_out = reset & RegWrite_MEM & ~Stall_MEM & ~fault_q;
  assign ReadData_MEM = rdata_q;
  assign MemFault     = fault_q;
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_be      = be_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: table of transactions with a scoreboard queue,
// plus hand-written reset/timeout sequences.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead_MEM, MemWrite_MEM;
  logic [1:0]  MemSize_MEM;
  logic        LoadUnsigned_MEM;
  logic [31:0] ALUOut_MEM, WriteData_MEM;
  logic        RegWrite_MEM;
  logic        RegWrite_out;
  logic [31:0] ReadData_MEM;
  logic        Stall_MEM, MemFault;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(16), .TCNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM), .MemSize_MEM(MemSize_MEM),
    .LoadUnsigned_MEM(LoadUnsigned_MEM), .ALUOut_MEM(ALUOut_MEM), .WriteData_MEM(WriteData_MEM),
    .RegWrite_MEM(RegWrite_MEM), .RegWrite_out(RegWrite_out), .ReadData_MEM(ReadData_MEM),
    .Stall_MEM(Stall_MEM), .MemFault(MemFault), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wdata;
    logic        rw;
    int          ack_at;     // WAIT cycle (1-based) carrying the ack; 0 = never
    logic [31:0] rdata;
    int          exp_stall;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_we;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    logic        exp_rw;
  } vec_t;

  vec_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    MemRead_MEM = 1'b0; MemWrite_MEM = 1'b0; MemSize_MEM = 2'b10; LoadUnsigned_MEM = 1'b0;
    ALUOut_MEM = '0; WriteData_MEM = '0; RegWrite_MEM = 1'b0;
  endtask

  task automatic run_txn(input string id, input vec_t v);
    vec_t        e;
    int          stalls = 0;
    int          waits = 0;
    bit          done = 0;
    logic        req_seen = 0, unstable = 0, rw_bad = 0, fault_early = 0;
    logic [31:0] a0 = '0, wd0 = '0;
    logic [3:0]  be0 = '0;
    logic        we0 = 0;
    @(negedge clk);
    MemRead_MEM = v.rd; MemWrite_MEM = v.wr; MemSize_MEM = v.size; LoadUnsigned_MEM = v.uns;
    ALUOut_MEM = v.addr; WriteData_MEM = v.wdata; RegWrite_MEM = v.rw; dmem_ack = 1'b0;
    sb_q.push_back(v);
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) begin
        @(negedge clk);
        dmem_ack = 1'b0;
      end
      #1;
      if (!Stall_MEM) begin
        done = 1;
      end else begin
        stalls++;
        if (RegWrite_out) rw_bad = 1;
        if (MemFault) fault_early = 1;
        if (dmem_req) begin
          waits++;
          if (!req_seen) begin
            a0 = dmem_addr; be0 = dmem_be; wd0 = dmem_wdata; we0 = dmem_we;
          end else if (a0 !== dmem_addr || be0 !== dmem_be || wd0 !== dmem_wdata || we0 !== dmem_we) begin
            unstable = 1;
          end
          req_seen = 1;
          if (waits == v.ack_at) begin
            dmem_ack = 1'b1;
            dmem_rdata = v.rdata;
          end
        end
      end
    end
    check({id, "_completes"}, 32'(done), 32'd1);
    e = sb_q.pop_front();
    check({id, "_stall_cycles"}, stalls, e.exp_stall);
    check({id, "_req_seen"}, 32'(req_seen), 32'(e.exp_req));
    if (e.exp_req) begin
      check({id, "_addr"}, a0, e.exp_addr);
      check({id, "_be"}, 32'(be0), 32'(e.exp_be));
      check({id, "_wdata"}, wd0, e.exp_wdata);
      check({id, "_we"}, 32'(we0), 32'(e.exp_we));
      check({id, "_req_stable"}, 32'(unstable), 32'd0);
    end
    check({id, "_rw_during_stall"}, 32'(rw_bad), 32'd0);
    check({id, "_fault_during_stall"}, 32'(fault_early), 32'd0);
    check({id, "_readdata"}, ReadData_MEM, e.exp_rdata);
    check({id, "_memfault"}, 32'(MemFault), 32'(e.exp_fault));
    check({id, "_regwrite_out"}, 32'(RegWrite_out), 32'(e.exp_rw));
    check({id, "_req_dropped"}, 32'(dmem_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[15];
    vec_t post;
    // rd wr size uns addr wdata rw ack_at rdata | stall req addr be wdata we rdata fault rw
    vecs[0]  = '{1,0,2'b10,0,32'h100,32'h0,1,1,32'hDEADBEEF,  2,1,32'h100,4'hF,32'h0,0,32'hDEADBEEF,0,1};
    vecs[1]  = '{1,0,2'b00,0,32'h103,32'h0,1,1,32'h80FF7F01,  2,1,32'h100,4'h8,32'h0,0,32'hFFFFFF80,0,1};
    vecs[2]  = '{1,0,2'b00,1,32'h103,32'h0,1,1,32'h80FF7F01,  2,1,32'h100,4'h8,32'h0,0,32'h00000080,0,1};
    vecs[3]  = '{0,1,2'b01,0,32'h202,32'h1234ABCD,0,4,32'h0,  5,1,32'h200,4'hC,32'hABCDABCD,1,32'h0,0,0};
    vecs[4]  = '{1,0,2'b10,0,32'h101,32'h0,1,1,32'h0,         1,0,32'h0,4'h0,32'h0,0,32'h0,1,0};
    vecs[5]  = '{1,0,2'b10,0,32'h300,32'h0,1,0,32'h0,         17,1,32'h300,4'hF,32'h0,0,32'h0,1,0};
    vecs[6]  = '{1,0,2'b10,0,32'h304,32'h0,1,16,32'h11223344, 17,1,32'h304,4'hF,32'h0,0,32'h11223344,0,1};
    vecs[7]  = '{1,0,2'b01,0,32'h402,32'h0,1,2,32'h80017FFF,  3,1,32'h400,4'hC,32'h0,0,32'hFFFF8001,0,1};
    vecs[8]  = '{1,0,2'b01,1,32'h400,32'h0,1,1,32'h8001F00D,  2,1,32'h400,4'h3,32'h0,0,32'h0000F00D,0,1};
    vecs[9]  = '{0,1,2'b00,0,32'h501,32'h000000A5,0,3,32'h0,  4,1,32'h500,4'h2,32'hA5A5A5A5,1,32'h0,0,0};
    vecs[10] = '{1,1,2'b10,0,32'h600,32'hCAFEF00D,1,1,32'hFFFFFFFF, 2,1,32'h600,4'hF,32'hCAFEF00D,1,32'h0,0,1};
    vecs[11] = '{1,0,2'b01,0,32'h203,32'h0,1,1,32'h0,         1,0,32'h0,4'h0,32'h0,0,32'h0,1,0};
    vecs[12] = '{1,0,2'b11,0,32'h700,32'h0,1,1,32'h5A5A5A5A,  2,1,32'h700,4'hF,32'h0,0,32'h5A5A5A5A,0,1};
    vecs[13] = '{0,0,2'b00,0,32'h0,32'h0,1,0,32'h0,           0,0,32'h0,4'h0,32'h0,0,32'h5A5A5A5A,0,1};
    vecs[14] = '{1,0,2'b00,0,32'h001,32'h0,1,1,32'h00008000,  2,1,32'h000,4'h2,32'h0,0,32'hFFFFFF80,0,1};
    post     = '{1,0,2'b10,0,32'h804,32'h0,1,2,32'h0BADF00D,  3,1,32'h804,4'hF,32'h0,0,32'h0BADF00D,0,1};

    // Reset held with an access and RegWrite pending: pipeline must be released.
    drive_idle();
    dmem_ack = 1'b0; dmem_rdata = '0;
    reset = 1'b0;
    MemRead_MEM = 1'b1; RegWrite_MEM = 1'b1; ALUOut_MEM = 32'h100;
    #12;
    check("rst_stall", 32'(Stall_MEM), 32'd0);
    check("rst_regwrite_out", 32'(RegWrite_out), 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_outputs", {dmem_addr | dmem_wdata | ReadData_MEM}, 32'h0);
    check("rst_flags", {28'h0, dmem_be} | 32'(MemFault) | 32'(dmem_we), 32'h0);
    @(negedge clk);
    drive_idle();
    reset = 1'b1;

    for (int i = 0; i < 15; i++) run_txn($sformatf("v%0d", i), vecs[i]);

    // Reset mid-WAIT: outputs clear at once, a late ack is ignored, next load is normal.
    @(negedge clk);
    MemRead_MEM = 1'b1; MemWrite_MEM = 1'b0; MemSize_MEM = 2'b10; ALUOut_MEM = 32'h800;
    RegWrite_MEM = 1'b1; dmem_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("midwait_req_before_reset", 32'(dmem_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("midwait_rst_req", 32'(dmem_req), 32'd0);
    check("midwait_rst_stall", 32'(Stall_MEM), 32'd0);
    check("midwait_rst_regwrite_out", 32'(RegWrite_out), 32'd0);
    check("midwait_rst_readdata", ReadData_MEM, 32'h0);
    check("midwait_rst_addr", dmem_addr, 32'h0);
    check("midwait_rst_be", 32'(dmem_be), 32'd0);
    drive_idle();
    @(negedge clk);
    reset = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'h77777777;
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    check("late_ack_req", 32'(dmem_req), 32'd0);
    check("late_ack_readdata", ReadData_MEM, 32'h0);
    check("late_ack_fault", 32'(MemFault), 32'd0);
    run_txn("post_reset", post);

    @(negedge clk);
    drive_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
